// File: rtl/ram_control_unit.sv
// ram_control_unit: multi-cycle LEGv8 sequencer that fetches over req/ack, decodes and drives the RAM datapath control word.
// Optional feature macro CBZ_EN: decode CBZ/CBNZ; without it both opcodes halt as illegal.
module ram_control_unit #(
  parameter logic [63:0] PC_RESET   = 64'h0,
  parameter int          MEM_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        instr_req,
  input  logic        instr_ack,
  input  logic [31:0] instr,
  output logic [63:0] pc,
  input  logic [63:0] pc_in,
  input  logic [3:0]  status,
  output logic [4:0]  SA,
  output logic [4:0]  SB,
  output logic [4:0]  DA,
  output logic [4:0]  FS,
  output logic [63:0] K,
  output logic        W,
  output logic        EN_ALU,
  output logic        EN_B,
  output logic        EN_ADDR,
  output logic        K_SEL,
  output logic        PC_SEL,
  output logic        C0,
  output logic        WE,
  output logic        OE,
  output logic        halt
);

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_HALT} state_t;
  typedef enum logic [3:0] {OP_ADD, OP_SUB, OP_ADDI, OP_SUBI, OP_LDUR, OP_STUR,
                            OP_BR, OP_B, OP_CBZ, OP_CBNZ, OP_ILL} op_t;

  typedef struct packed {
    logic [4:0]  sa;
    logic [4:0]  sb;
    logic [4:0]  da;
    logic [4:0]  fs;
    logic [63:0] k;
    logic        w;
    logic        en_alu;
    logic        en_b;
    logic        en_addr;
    logic        k_sel;
    logic        pc_sel;
    logic        c0;
    logic        we;
    logic        oe;
  } cw_t;

  localparam logic [4:0] FS_ADD   = 5'b01000;
  localparam logic [4:0] FS_SUB   = 5'b01010;
  localparam logic [2:0] MEM_LAST = 3'(MEM_CYCLES - 1);
  localparam cw_t CW_IDLE = '{sa: 5'd31, sb: 5'd31, da: 5'd31, fs: 5'd0, k: 64'd0,
                              w: 1'b0, en_alu: 1'b0, en_b: 1'b0, en_addr: 1'b0, k_sel: 1'b0,
                              pc_sel: 1'b0, c0: 1'b0, we: 1'b0, oe: 1'b0};

  state_t      state, state_n;
  op_t         op;
  cw_t         cw_q, cw_n, cw_exec, cw_mem;
  logic [31:0] ir;
  logic [63:0] pc_q, pc_n;
  logic [2:0]  cnt, cnt_n;
  logic        req_q;

  // Instruction fields
  logic [4:0]  rd, rn, rm;
  logic [63:0] imm12_z, imm9_s, br26;
  assign rd      = ir[4:0];
  assign rn      = ir[9:5];
  assign rm      = ir[20:16];
  assign imm12_z = {52'd0, ir[21:10]};
  assign imm9_s  = {{55{ir[20]}}, ir[20:12]};
  assign br26    = {{36{ir[25]}}, ir[25:0], 2'b00};

`ifdef CBZ_EN
  logic [63:0] br19;
  logic        cb_taken;
  logic [2:0]  unused_status;
  assign br19          = {{43{ir[23]}}, ir[23:5], 2'b00};
  assign cb_taken      = (op == OP_CBZ) ? status[0] : ~status[0];
  assign unused_status = status[3:1];
`else
  logic [3:0]  unused_status;
  assign unused_status = status;
`endif

  always_comb begin
    op = OP_ILL;
    if      (ir[31:21] == 11'b10001011000) op = OP_ADD;
    else if (ir[31:21] == 11'b11001011000) op = OP_SUB;
    else if (ir[31:22] == 10'b1001000100)  op = OP_ADDI;
    else if (ir[31:22] == 10'b1101000100)  op = OP_SUBI;
    else if (ir[31:21] == 11'b11111000010) op = OP_LDUR;
    else if (ir[31:21] == 11'b11111000000) op = OP_STUR;
    else if (ir[31:21] == 11'b11010110000) op = OP_BR;
    else if (ir[31:26] == 6'b000101)       op = OP_B;
`ifdef CBZ_EN
    else if (ir[31:24] == 8'b10110100)     op = OP_CBZ;
    else if (ir[31:24] == 8'b10110101)     op = OP_CBNZ;
`endif
  end

  always_comb begin
    cw_exec = CW_IDLE;
    case (op)
      OP_ADD, OP_SUB: begin
        cw_exec.sa     = rn;
        cw_exec.sb     = rm;
        cw_exec.da     = rd;
        cw_exec.fs     = (op == OP_SUB) ? FS_SUB : FS_ADD;
        cw_exec.c0     = (op == OP_SUB);
        cw_exec.en_alu = 1'b1;
        cw_exec.w      = 1'b1;
      end
      OP_ADDI, OP_SUBI: begin
        cw_exec.sa     = rn;
        cw_exec.da     = rd;
        cw_exec.k      = imm12_z;
        cw_exec.k_sel  = 1'b1;
        cw_exec.fs     = (op == OP_SUBI) ? FS_SUB : FS_ADD;
        cw_exec.c0     = (op == OP_SUBI);
        cw_exec.en_alu = 1'b1;
        cw_exec.w      = 1'b1;
      end
      OP_LDUR, OP_STUR: begin
        cw_exec.sa      = rn;
        cw_exec.k       = imm9_s;
        cw_exec.k_sel   = 1'b1;
        cw_exec.fs      = FS_ADD;
        cw_exec.en_addr = 1'b1;
      end
      OP_BR: begin
        cw_exec.sa     = rn;
        cw_exec.pc_sel = 1'b1;
      end
      OP_CBZ, OP_CBNZ: begin
        // Pass Rt through the ALU (Rt + 0) so the datapath refreshes Z.
        cw_exec.sa     = rd;
        cw_exec.fs     = FS_ADD;
        cw_exec.k_sel  = 1'b1;
        cw_exec.en_alu = 1'b1;
      end
      default: ;
    endcase
  end

  // Address computation (Rn + imm9) stays on the bus for the whole access.
  always_comb begin
    cw_mem         = CW_IDLE;
    cw_mem.sa      = rn;
    cw_mem.k       = imm9_s;
    cw_mem.k_sel   = 1'b1;
    cw_mem.fs      = FS_ADD;
    cw_mem.en_addr = 1'b1;
    if (op == OP_STUR) begin
      cw_mem.sb   = rd;
      cw_mem.en_b = 1'b1;
      cw_mem.we   = 1'b1;
    end else begin
      cw_mem.da = rd;
      cw_mem.oe = 1'b1;
      cw_mem.w  = (cnt_n == MEM_LAST);
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    pc_n    = pc_q;
    case (state)
      S_FETCH:  if (req_q && instr_ack) state_n = S_DECODE;
      S_DECODE: state_n = (op == OP_ILL) ? S_HALT : S_EXEC;
      S_EXEC: begin
        if (op == OP_LDUR || op == OP_STUR) begin
          state_n = S_MEM;
          cnt_n   = 3'd0;
        end else begin
          state_n = S_FETCH;
          case (op)
            OP_BR:   pc_n = pc_in;
            OP_B:    pc_n = pc_q + br26;
`ifdef CBZ_EN
            OP_CBZ, OP_CBNZ: pc_n = cb_taken ? pc_q + br19 : pc_q + 64'd4;
`endif
            default: pc_n = pc_q + 64'd4;
          endcase
        end
      end
      S_MEM: begin
        if (cnt == MEM_LAST) begin
          state_n = S_FETCH;
          pc_n    = pc_q + 64'd4;
        end else begin
          cnt_n = cnt + 3'd1;
        end
      end
      S_HALT:  state_n = S_HALT;
      default: state_n = S_FETCH;
    endcase
  end

  always_comb begin
    cw_n = CW_IDLE;
    if (state_n == S_EXEC)     cw_n = cw_exec;
    else if (state_n == S_MEM) cw_n = cw_mem;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_FETCH;
    else      state <= state_n;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q  <= PC_RESET;
      cnt   <= 3'd0;
      req_q <= 1'b0;
      ir    <= 32'd0;
      cw_q  <= CW_IDLE;
    end else begin
      pc_q  <= pc_n;
      cnt   <= cnt_n;
      req_q <= (state_n == S_FETCH);
      cw_q  <= cw_n;
      if (state == S_FETCH && req_q && instr_ack) ir <= instr;
    end
  end

  assign instr_req = req_q;
  assign pc        = pc_q;
  assign halt      = (state == S_HALT);
  assign SA        = cw_q.sa;
  assign SB        = cw_q.sb;
  assign DA        = cw_q.da;
  assign FS        = cw_q.fs;
  assign K         = cw_q.k;
  assign W         = cw_q.w;
  assign EN_ALU    = cw_q.en_alu;
  assign EN_B      = cw_q.en_b;
  assign EN_ADDR   = cw_q.en_addr;
  assign K_SEL     = cw_q.k_sel;
  assign PC_SEL    = cw_q.pc_sel;
  assign C0        = cw_q.c0;
  assign WE        = cw_q.we;
  assign OE        = cw_q.oe;

endmodule

// File: tb/tb_ram_control_unit.sv
// Directed bench for ram_control_unit: fetch handshake, per-opcode control words, PC update, halt and async reset.
module tb_ram_control_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        instr_req, instr_ack;
  logic [31:0] instr;
  logic [63:0] pc, pc_in, K;
  logic [3:0]  status;
  logic [4:0]  SA, SB, DA, FS;
  logic        W, EN_ALU, EN_B, EN_ADDR, K_SEL, PC_SEL, C0, WE, OE, halt;
  int total = 0;
  int bad   = 0;

  ram_control_unit #(.PC_RESET(64'h0), .MEM_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .instr_req(instr_req), .instr_ack(instr_ack), .instr(instr),
    .pc(pc), .pc_in(pc_in), .status(status), .SA(SA), .SB(SB), .DA(DA), .FS(FS), .K(K),
    .W(W), .EN_ALU(EN_ALU), .EN_B(EN_B), .EN_ADDR(EN_ADDR), .K_SEL(K_SEL), .PC_SEL(PC_SEL),
    .C0(C0), .WE(WE), .OE(OE), .halt(halt)
  );

  always #5 clk = ~clk;

  // Waits (bounded) for instr_req, presents one word for one cycle; returns at the DECODE negedge.
  task automatic do_fetch(input logic [31:0] w);
    int n = 0;
    while (instr_req !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    total++; if (instr_req !== 1'b1) begin bad++; $display("FAIL fetch_timeout req=%b exp=1", instr_req); end
    instr = w; instr_ack = 1'b1;
    @(negedge clk);
    instr_ack = 1'b0; instr = 32'h0;
  endtask

  task automatic reset_pulse;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset;
    instr_ack = 1'b0; instr = 32'h0; pc_in = 64'h0; status = 4'h0;
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (instr_req !== 1'b0) begin bad++; $display("FAIL rst_req got=%b exp=0", instr_req); end
    total++; if (pc !== 64'h0) begin bad++; $display("FAIL rst_pc got=%h exp=0", pc); end
    total++; if (halt !== 1'b0) begin bad++; $display("FAIL rst_halt got=%b exp=0", halt); end
    total++; if ({W,EN_ALU,EN_B,EN_ADDR,K_SEL,PC_SEL,C0,WE,OE} !== 9'h0) begin bad++; $display("FAIL rst_ctl got=%b exp=0", {W,EN_ALU,EN_B,EN_ADDR,K_SEL,PC_SEL,C0,WE,OE}); end
    total++; if ({SA,SB,DA} !== {5'd31,5'd31,5'd31}) begin bad++; $display("FAIL rst_regs got=%0d/%0d/%0d exp=31/31/31", SA, SB, DA); end
    total++; if (FS !== 5'd0 || K !== 64'd0) begin bad++; $display("FAIL rst_fsk got=%b/%h exp=0/0", FS, K); end
    rst = 1'b1;
    total++; if (instr_req !== 1'b0) begin bad++; $display("FAIL rel_req0 got=%b exp=0", instr_req); end
    @(negedge clk);
    total++; if (instr_req !== 1'b1) begin bad++; $display("FAIL rel_req1 got=%b exp=1", instr_req); end
    total++; if (pc !== 64'h0) begin bad++; $display("FAIL rel_pc got=%h exp=0", pc); end
  endtask

  task automatic test_addi;
    do_fetch(32'h9100_3FE0);
    total++; if (W !== 1'b0) begin bad++; $display("FAIL addi_decode_w got=%b exp=0", W); end
    @(negedge clk);
    total++; if (DA !== 5'd0 || SA !== 5'd31) begin bad++; $display("FAIL addi_regs got=DA%0d SA%0d exp=DA0 SA31", DA, SA); end
    total++; if (K !== 64'd15 || K_SEL !== 1'b1) begin bad++; $display("FAIL addi_k got=%h/%b exp=f/1", K, K_SEL); end
    total++; if (FS !== 5'b01000 || C0 !== 1'b0) begin bad++; $display("FAIL addi_fs got=%b/%b exp=01000/0", FS, C0); end
    total++; if (EN_ALU !== 1'b1 || W !== 1'b1) begin bad++; $display("FAIL addi_en got=%b/%b exp=1/1", EN_ALU, W); end
    @(negedge clk);
    total++; if (W !== 1'b0 || EN_ALU !== 1'b0) begin bad++; $display("FAIL addi_one_cycle got=%b/%b exp=0/0", W, EN_ALU); end
    total++; if (pc !== 64'h4) begin bad++; $display("FAIL addi_pc got=%h exp=4", pc); end
    total++; if (instr_req !== 1'b1) begin bad++; $display("FAIL addi_req got=%b exp=1", instr_req); end
  endtask

  task automatic test_sub;
    do_fetch(32'hCB02_0024);
    @(negedge clk);
    total++; if (FS !== 5'b01010 || C0 !== 1'b1) begin bad++; $display("FAIL sub_fs got=%b/%b exp=01010/1", FS, C0); end
    total++; if (SA !== 5'd1 || SB !== 5'd2 || DA !== 5'd4) begin bad++; $display("FAIL sub_regs got=%0d/%0d/%0d exp=1/2/4", SA, SB, DA); end
    total++; if (W !== 1'b1 || K_SEL !== 1'b0) begin bad++; $display("FAIL sub_w got=%b/%b exp=1/0", W, K_SEL); end
    @(negedge clk);
    total++; if (pc !== 64'h8) begin bad++; $display("FAIL sub_pc got=%h exp=8", pc); end
  endtask

  task automatic test_stur;
    do_fetch(32'hF800_0002);
    @(negedge clk);
    total++; if (EN_ADDR !== 1'b1 || WE !== 1'b0 || K_SEL !== 1'b1) begin bad++; $display("FAIL stur_exec got=%b/%b/%b exp=1/0/1", EN_ADDR, WE, K_SEL); end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      total++; if ({WE,EN_B,EN_ADDR} !== 3'b111) begin bad++; $display("FAIL stur_mem%0d got=%b exp=111", c, {WE,EN_B,EN_ADDR}); end
      total++; if (SB !== 5'd2 || W !== 1'b0) begin bad++; $display("FAIL stur_sb%0d got=%0d/%b exp=2/0", c, SB, W); end
      total++; if (pc !== 64'h8) begin bad++; $display("FAIL stur_pc_hold%0d got=%h exp=8", c, pc); end
    end
    @(negedge clk);
    total++; if (WE !== 1'b0 || EN_B !== 1'b0) begin bad++; $display("FAIL stur_end got=%b/%b exp=0/0", WE, EN_B); end
    total++; if (pc !== 64'hC) begin bad++; $display("FAIL stur_pc got=%h exp=c", pc); end
  endtask

  task automatic test_ldur;
    do_fetch(32'hF840_0006);
    @(negedge clk);
    total++; if (OE !== 1'b0 || EN_ADDR !== 1'b1) begin bad++; $display("FAIL ldur_exec got=%b/%b exp=0/1", OE, EN_ADDR); end
    @(negedge clk);
    total++; if (OE !== 1'b1 || DA !== 5'd6 || W !== 1'b0) begin bad++; $display("FAIL ldur_mem0 got=%b/%0d/%b exp=1/6/0", OE, DA, W); end
    @(negedge clk);
    total++; if (OE !== 1'b1 || DA !== 5'd6 || W !== 1'b1) begin bad++; $display("FAIL ldur_mem1 got=%b/%0d/%b exp=1/6/1", OE, DA, W); end
    @(negedge clk);
    total++; if (OE !== 1'b0 || W !== 1'b0) begin bad++; $display("FAIL ldur_end got=%b/%b exp=0/0", OE, W); end
    total++; if (pc !== 64'h10) begin bad++; $display("FAIL ldur_pc got=%h exp=10", pc); end
  endtask

  task automatic test_branch;
    pc_in = 64'hF;
    do_fetch(32'hD61F_00C0);
    @(negedge clk);
    total++; if (PC_SEL !== 1'b1 || SA !== 5'd6) begin bad++; $display("FAIL br_exec got=%b/%0d exp=1/6", PC_SEL, SA); end
    @(negedge clk);
    total++; if (pc !== 64'hF || instr_req !== 1'b1) begin bad++; $display("FAIL br_pc got=%h/%b exp=f/1", pc, instr_req); end
    do_fetch(32'h17FF_FFFF);
    @(negedge clk);
    @(negedge clk);
    total++; if (pc !== 64'hB) begin bad++; $display("FAIL b_back_pc got=%h exp=b", pc); end
    pc_in = 64'hFFFF_FFFF_FFFF_FFFC;
    do_fetch(32'hD61F_00C0);
    @(negedge clk);
    @(negedge clk);
    total++; if (pc !== 64'hFFFF_FFFF_FFFF_FFFC) begin bad++; $display("FAIL br_top_pc got=%h exp=fffffffffffffffc", pc); end
    do_fetch(32'h8B03_0041);
    @(negedge clk);
    total++; if (SA !== 5'd2 || SB !== 5'd3 || DA !== 5'd1 || FS !== 5'b01000 || C0 !== 1'b0) begin bad++; $display("FAIL add_exec got=%0d/%0d/%0d/%b/%b exp=2/3/1/01000/0", SA, SB, DA, FS, C0); end
    @(negedge clk);
    total++; if (pc !== 64'h0) begin bad++; $display("FAIL pc_wrap got=%h exp=0", pc); end
  endtask

  task automatic test_cbz;
    status = 4'b0001;
    do_fetch(32'hB400_0043);
    @(negedge clk);
`ifdef CBZ_EN
    total++; if (SA !== 5'd3 || EN_ALU !== 1'b1 || K_SEL !== 1'b1 || W !== 1'b0) begin bad++; $display("FAIL cbz_exec got=%0d/%b/%b/%b exp=3/1/1/0", SA, EN_ALU, K_SEL, W); end
    total++; if (K !== 64'h0 || FS !== 5'b01000) begin bad++; $display("FAIL cbz_k got=%h/%b exp=0/01000", K, FS); end
    @(negedge clk);
    total++; if (pc !== 64'h8) begin bad++; $display("FAIL cbz_pc got=%h exp=8", pc); end
`else
    total++; if (halt !== 1'b1 || instr_req !== 1'b0) begin bad++; $display("FAIL cbz_illegal got=%b/%b exp=1/0", halt, instr_req); end
    total++; if (pc !== 64'h0) begin bad++; $display("FAIL cbz_illegal_pc got=%h exp=0", pc); end
`endif
    status = 4'b0000;
    reset_pulse();
  endtask

  task automatic test_halt;
    do_fetch(32'h9100_3FE0);
    @(negedge clk);
    @(negedge clk);
    do_fetch(32'h0000_0000);
    @(negedge clk);
    for (int c = 0; c < 10; c++) begin
      instr_ack = 1'b1; instr = 32'h9100_3FE0;
      total++; if (halt !== 1'b1) begin bad++; $display("FAIL halt_flag%0d got=%b exp=1", c, halt); end
      total++; if (instr_req !== 1'b0) begin bad++; $display("FAIL halt_req%0d got=%b exp=0", c, instr_req); end
      total++; if (pc !== 64'h4 || W !== 1'b0) begin bad++; $display("FAIL halt_pc%0d got=%h/%b exp=4/0", c, pc, W); end
      @(negedge clk);
    end
    instr_ack = 1'b0; instr = 32'h0;
  endtask

  task automatic test_ack_ignored;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    total++; if (halt !== 1'b0) begin bad++; $display("FAIL halt_cleared got=%b exp=0", halt); end
    instr_ack = 1'b1; instr = 32'h9100_3FE0;
    @(negedge clk);
    instr_ack = 1'b0; instr = 32'h0;
    total++; if (instr_req !== 1'b1) begin bad++; $display("FAIL ack_ignored_req got=%b exp=1", instr_req); end
    @(negedge clk);
    total++; if (instr_req !== 1'b1 || W !== 1'b0) begin bad++; $display("FAIL ack_ignored_hold got=%b/%b exp=1/0", instr_req, W); end
    do_fetch(32'hCB02_0024);
    @(negedge clk);
    total++; if (FS !== 5'b01010 || DA !== 5'd4) begin bad++; $display("FAIL ack_real_fetch got=%b/%0d exp=01010/4", FS, DA); end
    @(negedge clk);
    total++; if (pc !== 64'h4) begin bad++; $display("FAIL ack_pc got=%h exp=4", pc); end
  endtask

  task automatic test_reset_mid;
    do_fetch(32'hF840_0006);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    total++; if (W !== 1'b1 || OE !== 1'b1) begin bad++; $display("FAIL mid_pre got=%b/%b exp=1/1", W, OE); end
    rst = 1'b0;
    #1;
    total++; if (W !== 1'b0 || OE !== 1'b0) begin bad++; $display("FAIL mid_drop got=%b/%b exp=0/0", W, OE); end
    total++; if (DA !== 5'd31 || EN_ADDR !== 1'b0) begin bad++; $display("FAIL mid_idle got=%0d/%b exp=31/0", DA, EN_ADDR); end
    total++; if (pc !== 64'h0 || instr_req !== 1'b0) begin bad++; $display("FAIL mid_pc got=%h/%b exp=0/0", pc, instr_req); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    total++; if (instr_req !== 1'b1 || pc !== 64'h0) begin bad++; $display("FAIL mid_restart got=%b/%h exp=1/0", instr_req, pc); end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_sub();
    test_stur();
    test_ldur();
    test_branch();
    test_cbz();
    test_halt();
    test_ack_ignored();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
